// File: rtl/axi_read_master_pkg.sv
// Shared encodings and types for the AXI read master.
package axi_rd_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        SIZE_1B = 2'b00,
        SIZE_2B = 2'b01,
        SIZE_4B = 2'b10
    } size_e;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_e;

    localparam int          RD_DATA_W     = 32;
    localparam int          FIFO_DEPTH    = 4;
    localparam logic [2:0]  FIFO_FULL_CNT = 3'd4;

    typedef struct packed {
        logic                 id;
        logic [RD_DATA_W-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } resp_entry_t;

endpackage

// File: rtl/axi_read_master_resp_fifo.sv
// Four-entry response FIFO; head entry is presented directly from storage.
module rm_resp_fifo
    import axi_rd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  resp_entry_t push_data,
    input  logic        pop,
    output resp_entry_t head,
    output logic        full,
    output logic        empty
);

    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    resp_entry_t mem_q [FIFO_DEPTH];
    logic        do_push_s, do_pop_s;

    assign full      = (count_q == FIFO_FULL_CNT);
    assign empty     = (count_q == 3'd0);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_q[rd_ptr_q];

    // Pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule

// File: rtl/axi_read_master.sv
// AXI read master: AR issue FSM, per-ID busy tracking, R capture into a response FIFO.
// Optional beat-count/ID protocol checking is enabled by defining READ_MASTER_LEN_CHECK_EN.
module axi_read_master
    import axi_rd_pkg::*;
#(
    parameter int   BusWidth   = RD_DATA_W,
    parameter int   tagbits    = 2,
    parameter logic MASTER_NUM = 1'b0
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_id,
    input  logic [BusWidth-1:0] req_addr,
    input  logic [1:0]          req_len,
    input  logic [1:0]          req_size,
    input  logic [1:0]          req_burst,
    output logic [tagbits-1:0]  ARID,
    output logic [BusWidth-1:0] ARADDR,
    output logic [3:0]          ARLEN,
    output logic [1:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic [1:0]          ARLOCK,
    output logic [3:0]          ARCACHE,
    output logic [2:0]          ARPROT,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [tagbits-1:0]  RID,
    input  logic [BusWidth-1:0] RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [BusWidth-1:0] resp_data,
    output logic [1:0]          resp_resp,
    output logic                resp_last,
    output logic [1:0]          busy,
    output logic                err
);

    ar_state_e           state_q, state_d;
    logic                arvalid_q, arvalid_d;
    logic                arid_q, arid_d;
    logic [BusWidth-1:0] araddr_q, araddr_d;
    logic [1:0]          arlen_q, arlen_d;
    logic [1:0]          arsize_q, arsize_d;
    logic [1:0]          arburst_q, arburst_d;
    logic [1:0]          busy_q, busy_d;
    logic                err_q, err_d;

    logic        accept_s, beat_s, push_s, pop_s;
    logic        fifo_full_s, fifo_empty_s;
    resp_entry_t push_entry_s, head_s;

    assign req_ready = (state_q == AR_IDLE) && !busy_q[req_id];
    assign accept_s  = req_valid && req_ready;
    assign RREADY    = !fifo_full_s;
    assign beat_s    = RVALID && RREADY;
    assign pop_s     = !fifo_empty_s && resp_ready;

    assign ARID    = {MASTER_NUM, arid_q};
    assign ARADDR  = araddr_q;
    assign ARLEN   = {2'b00, arlen_q};
    assign ARSIZE  = arsize_q;
    assign ARBURST = arburst_q;
    assign ARLOCK  = 2'b00;
    assign ARCACHE = 4'b0000;
    assign ARPROT  = 3'b000;
    assign ARVALID = arvalid_q;
    assign busy    = busy_q;
    assign err     = err_q;

    // AR state register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= AR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // AR next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            AR_IDLE: begin
                if (accept_s) begin
                    state_d = AR_SEND;
                end else begin
                    state_d = AR_IDLE;
                end
            end
            AR_SEND: begin
                if (ARREADY) begin
                    state_d = AR_IDLE;
                end else begin
                    state_d = AR_SEND;
                end
            end
            default: state_d = AR_IDLE;
        endcase
    end

    // AR output logic; fields only load on accept so they stay frozen while ARVALID is high.
    always_comb begin
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        arvalid_d = (state_d == AR_SEND);
        if (accept_s) begin
            arid_d    = req_id;
            araddr_d  = req_addr;
            arlen_d   = req_len;
            arsize_d  = req_size;
            arburst_d = req_burst;
        end else begin
            arid_d    = arid_q;
            araddr_d  = araddr_q;
        end
    end

    // AR output registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            arvalid_q <= 1'b0;
            arid_q    <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= 2'd0;
            arsize_q  <= 2'd0;
            arburst_q <= 2'd0;
        end else begin
            arvalid_q <= arvalid_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
        end
    end

`ifdef READ_MASTER_LEN_CHECK_EN
    logic [1:0][2:0] cnt_q, cnt_d;
    logic            unexpected_s;

    assign unexpected_s = (RID[tagbits-1] != MASTER_NUM) || !busy_q[RID[0]];
    assign push_s       = beat_s && !unexpected_s;

    // Busy, beat-counter and sticky error update; unexpected beats are swallowed.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (beat_s) begin
            if (unexpected_s) begin
                err_d = 1'b1;
            end else begin
                if (RLAST && (cnt_q[RID[0]] != 3'd1)) begin
                    err_d = 1'b1;
                end else if (!RLAST && (cnt_q[RID[0]] == 3'd1)) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (cnt_q[RID[0]] != 3'd0) begin
                    cnt_d[RID[0]] = cnt_q[RID[0]] - 3'd1;
                end else begin
                    cnt_d[RID[0]] = 3'd0;
                end
                if (RLAST) begin
                    busy_d[RID[0]] = 1'b0;
                end else begin
                    busy_d[RID[0]] = busy_q[RID[0]];
                end
            end
        end else begin
            err_d = err_q;
        end
        if (accept_s) begin
            busy_d[req_id] = 1'b1;
            cnt_d[req_id]  = {1'b0, req_len} + 3'd1;
        end else begin
            busy_d[req_id] = busy_d[req_id];
        end
    end

    // Beat counter registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign push_s = beat_s;

    // Busy update: set on accept, cleared by RLAST of the matching local ID.
    always_comb begin
        busy_d = busy_q;
        err_d  = 1'b0;
        if (beat_s && RLAST) begin
            busy_d[RID[0]] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (accept_s) begin
            busy_d[req_id] = 1'b1;
        end else begin
            busy_d[req_id] = busy_d[req_id];
        end
    end
`endif

    // Busy and error registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            busy_q <= 2'b00;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign push_entry_s = '{id: RID[0], data: RDATA, resp: RRESP, last: RLAST};

    rm_resp_fifo u_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign resp_valid = !fifo_empty_s;
    assign resp_id    = head_s.id;
    assign resp_data  = head_s.data;
    assign resp_resp  = head_s.resp;
    assign resp_last  = head_s.last;

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master; error expectations follow READ_MASTER_LEN_CHECK_EN.
module tb_axi_read_master;

    logic        ACLK, ARESET;
    logic        req_valid, req_ready, req_id;
    logic [31:0] req_addr;
    logic [1:0]  req_len, req_size, req_burst;
    logic [1:0]  ARID, ARSIZE, ARBURST, ARLOCK;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN, ARCACHE;
    logic [2:0]  ARPROT;
    logic        ARVALID, ARREADY;
    logic [1:0]  RID, RRESP;
    logic [31:0] RDATA;
    logic        RLAST, RVALID, RREADY;
    logic        resp_valid, resp_ready, resp_id, resp_last;
    logic [31:0] resp_data;
    logic [1:0]  resp_resp, busy;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

`ifdef READ_MASTER_LEN_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    axi_read_master dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .req_addr(req_addr), .req_len(req_len), .req_size(req_size), .req_burst(req_burst),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_resp(resp_resp), .resp_last(resp_last),
        .busy(busy), .err(err)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic req(input logic id, input logic [31:0] addr, input logic [1:0] len);
        req_valid = 1'b1; req_id = id; req_addr = addr; req_len = len;
        req_size = 2'b10; req_burst = 2'b01;
        step();
        req_valid = 1'b0;
    endtask

    task automatic ar_hs();
        ARREADY = 1'b1;
        step();
        ARREADY = 1'b0;
    endtask

    task automatic beat(input logic [1:0] id, input logic [31:0] data, input logic last);
        RVALID = 1'b1; RID = id; RDATA = data; RLAST = last; RRESP = 2'b00;
        step();
        RVALID = 1'b0;
        #1;
    endtask

    initial begin
        ARESET = 1'b1; req_valid = 1'b0; req_id = 1'b0; req_addr = 32'd0;
        req_len = 2'd0; req_size = 2'd0; req_burst = 2'd0; ARREADY = 1'b0;
        RID = 2'd0; RDATA = 32'd0; RRESP = 2'd0; RLAST = 1'b0; RVALID = 1'b0;
        resp_ready = 1'b0;
        #2;
        chk("rst_arvalid", ARVALID, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_err", err, 32'd0);
        chk("rst_resp_valid", resp_valid, 32'd0);
        chk("rst_rready", RREADY, 32'd1);
        chk("rst_req_ready", req_ready, 32'd1);
        step();
        ARESET = 1'b0;

        // Reset while in AR_SEND with a beat buffered.
        req(1'b0, 32'h200, 2'd0);
        chk("t1_arvalid", ARVALID, 32'd1);
        chk("t1_busy", busy, 32'd1);
        beat(2'b00, 32'h55, 1'b0);
        chk("t1_resp_valid", resp_valid, 32'd1);
        ARESET = 1'b1;
        #1;
        chk("t1_rst_arvalid", ARVALID, 32'd0);
        chk("t1_rst_busy", busy, 32'd0);
        chk("t1_rst_resp_valid", resp_valid, 32'd0);
        chk("t1_rst_err", err, 32'd0);
        chk("t1_rst_araddr", ARADDR, 32'd0);
        step();
        ARESET = 1'b0;
        #1;

        // Single 4-beat INCR burst with AR back-pressure.
        req(1'b0, 32'h100, 2'd3);
        chk("t2_arvalid", ARVALID, 32'd1);
        chk("t2_arid", ARID, 32'd0);
        chk("t2_arlen", ARLEN, 32'd3);
        chk("t2_araddr", ARADDR, 32'h100);
        chk("t2_arsize", ARSIZE, 32'd2);
        chk("t2_arburst", ARBURST, 32'd1);
        chk("t2_busy", busy, 32'd1);
        chk("t2_req_ready", req_ready, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_arvalid_hold", ARVALID, 32'd1);
            chk("t2_araddr_hold", ARADDR, 32'h100);
        end
        ar_hs();
        chk("t2_arvalid_drop", ARVALID, 32'd0);
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat(2'b00, 32'hA0 + 32'(i), (i == 3));
            chk("t2_resp_valid", resp_valid, 32'd1);
            chk("t2_resp_data", resp_data, 32'hA0 + 32'(i));
            chk("t2_resp_last", resp_last, (i == 3) ? 32'd1 : 32'd0);
            chk("t2_resp_id", resp_id, 32'd0);
        end
        chk("t2_busy_clr", busy, 32'd0);
        chk("t2_err", err, 32'd0);
        step();
        chk("t2_empty", resp_valid, 32'd0);
        resp_ready = 1'b0;

        // Two IDs outstanding, beats return out of order.
        req(1'b0, 32'h300, 2'd0);
        ar_hs();
        req_id = 1'b1;
        #1;
        chk("t3_req_ready_id1", req_ready, 32'd1);
        req(1'b1, 32'h400, 2'd0);
        chk("t3_arid", ARID, 32'd1);
        ar_hs();
        chk("t3_busy", busy, 32'd3);
        req_valid = 1'b1; req_id = 1'b0;
        #1;
        chk("t3_req_ready_busy", req_ready, 32'd0);
        req_valid = 1'b0;
        beat(2'b01, 32'hB1, 1'b1);
        chk("t3_busy_id1_clr", busy, 32'd1);
        beat(2'b00, 32'hB0, 1'b1);
        chk("t3_busy_id0_clr", busy, 32'd0);
        chk("t3_head0_id", resp_id, 32'd1);
        chk("t3_head0_data", resp_data, 32'hB1);
        resp_ready = 1'b1;
        step();
        chk("t3_head1_id", resp_id, 32'd0);
        chk("t3_head1_data", resp_data, 32'hB0);
        step();
        chk("t3_empty", resp_valid, 32'd0);
        resp_ready = 1'b0;

        // FIFO full back-pressure on R.
        req(1'b0, 32'h500, 2'd3);
        ar_hs();
        req(1'b1, 32'h600, 2'd0);
        ar_hs();
        for (int i = 0; i < 4; i++) begin
            beat(2'b00, 32'hC0 + 32'(i), (i == 3));
            chk("t4_rready", RREADY, (i < 3) ? 32'd1 : 32'd0);
        end
        RVALID = 1'b1; RID = 2'b01; RDATA = 32'hC4; RLAST = 1'b1;
        step();
        chk("t4_stalled_busy", busy, 32'd2);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        #1;
        chk("t4_rready_after_pop", RREADY, 32'd1);
        chk("t4_busy_before", busy, 32'd2);
        step();
        RVALID = 1'b0;
        #1;
        chk("t4_busy_after", busy, 32'd0);
        chk("t4_full_again", RREADY, 32'd0);
        resp_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chk("t4_drain_data", resp_data, 32'hC0 + 32'(i));
            chk("t4_drain_id", resp_id, (i == 4) ? 32'd1 : 32'd0);
            step();
        end
        chk("t4_empty", resp_valid, 32'd0);
        resp_ready = 1'b0;
        chk("t4_err", err, 32'd0);

        // Early RLAST and a beat carrying the wrong master number.
        req(1'b0, 32'h700, 2'd1);
        ar_hs();
        beat(2'b00, 32'hD0, 1'b1);
        chk("t5_err_early_last", err, 32'(CHK));
        chk("t5_busy", busy, 32'd0);
        beat(2'b10, 32'hD1, 1'b0);
        chk("t5_err_master", err, 32'(CHK));
        resp_ready = 1'b1;
        chk("t5_head_data", resp_data, 32'hD0);
        step();
        chk("t5_second_valid", resp_valid, CHK ? 32'd0 : 32'd1);
        if (!CHK) begin
            chk("t5_second_data", resp_data, 32'hD1);
            chk("t5_second_id", resp_id, 32'd0);
        end
        step();
        step();
        chk("t5_err_sticky", err, 32'(CHK));
        chk("t5_drained", resp_valid, 32'd0);
        resp_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
